la_rle_decoder: RTL and testbench

Receive-side counterpart of the logic-analyzer trace compressor. Accepts 32-bit run-length trace words {rc[7:0], data[23:0]} on an AXI-Stream slave port and expands each word back into a cycle-accurate 24-bit waveform stream with valid/ready flow control. All-zero (null) words mark FIFO-overflow gaps and are replayed as a flagged gap beat. Used in loopback verification and the on-chip waveform replay path, all in the axi_clk domain.

---
 rtl/la_rle_decoder.sv | 181 ++++++++++++++++++
 tb/tb_la_rle_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/la_rle_decoder.sv
// Run-length trace decoder: expands {rc, data} words into a cycle-accurate waveform stream.
// Optional statistics counters are built when LA_RLE_DEC_STATS_EN is defined.
module la_rle_decoder #(
  parameter int WAVE_WIDTH = 24,
  parameter int RC_WIDTH   = 8,
  parameter int IN_DEPTH   = 4
) (
  input  logic                           axi_clk,
  input  logic                           axi_reset_n,
  input  logic                           dec_enable,
  input  logic [WAVE_WIDTH+RC_WIDTH-1:0] s_tdata,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic                           s_tlast,
  input  logic [1:0]                     s_tuser,
  output logic [WAVE_WIDTH-1:0]          wave_data,
  output logic                           wave_valid,
  output logic                           wave_gap,
  output logic                           wave_last,
  input  logic                           wave_ready,
  output logic [15:0]                    pkt_count,
  output logic [15:0]                    gap_count,
  output logic [31:0]                    beat_count
);

  localparam int TW    = WAVE_WIDTH + RC_WIDTH;
  localparam int PTR_W = $clog2(IN_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IN_DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  logic [TW:0]           mem_q [IN_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  tready_q;
  state_t                state_q;
  logic [RC_WIDTH-1:0]   remain_q;
  logic [WAVE_WIDTH-1:0] data_q;
  logic                  valid_q, gap_q, last_q, tlast_q;

  logic                  push, pop, load, empty, beat_acc, final_beat;
  logic [TW:0]           head;
  logic [RC_WIDTH-1:0]   head_rc;
  logic [WAVE_WIDTH-1:0] head_data;
  logic                  head_last;
  logic                  unused_tuser;

  assign unused_tuser = ^s_tuser;

  // s_tready is registered from the next-state fill level, then gated by the enable
  assign s_tready   = tready_q & dec_enable;
  assign push       = s_tvalid & s_tready;
  assign empty      = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_rc    = head[TW-1:WAVE_WIDTH];
  assign head_data  = head[WAVE_WIDTH-1:0];
  assign head_last  = head[TW];
  assign beat_acc   = valid_q & wave_ready;
  assign final_beat = (state_q == GAP) | (remain_q == RC_WIDTH'(1));
  assign load       = dec_enable & ((state_q == IDLE) | (beat_acc & final_beat));
  assign pop        = load & ~empty;

  always_comb begin
    count_d = count_q;
    if (!dec_enable) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      tready_q <= dec_enable & (count_d < DEPTH_C);
      if (!dec_enable) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Replay FSM; wave_data is left untouched on gap beats so the last known value persists
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      gap_q    <= 1'b0;
      last_q   <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (!dec_enable) begin
      state_q  <= IDLE;
      remain_q <= '0;
      valid_q  <= 1'b0;
      gap_q    <= 1'b0;
      last_q   <= 1'b0;
    end else if (load) begin
      if (empty) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        gap_q   <= 1'b0;
        last_q  <= 1'b0;
      end else if (head_rc == '0) begin
        state_q <= GAP;
        valid_q <= 1'b1;
        gap_q   <= 1'b1;
        last_q  <= head_last;
        tlast_q <= head_last;
      end else begin
        state_q  <= PLAY;
        remain_q <= head_rc;
        data_q   <= head_data;
        valid_q  <= 1'b1;
        gap_q    <= 1'b0;
        last_q   <= head_last & (head_rc == RC_WIDTH'(1));
        tlast_q  <= head_last;
      end
    end else if ((state_q == PLAY) && beat_acc) begin
      remain_q <= remain_q - 1'b1;
      last_q   <= tlast_q & (remain_q == RC_WIDTH'(2));
    end
  end

  assign wave_data  = data_q;
  assign wave_valid = valid_q;
  assign wave_gap   = gap_q;
  assign wave_last  = last_q;

`ifdef LA_RLE_DEC_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [15:0] pkt_q, gap_cnt_q;
  logic [31:0] beat_q;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      pkt_q     <= '0;
      gap_cnt_q <= '0;
      beat_q    <= '0;
    end else begin
      if (pop)                      pkt_q     <= sat_inc16(pkt_q);
      if (pop && (head_rc == '0))   gap_cnt_q <= sat_inc16(gap_cnt_q);
      if (beat_acc)                 beat_q    <= sat_inc32(beat_q);
    end
  end

  assign pkt_count  = pkt_q;
  assign gap_count  = gap_cnt_q;
  assign beat_count = beat_q;
`else
  assign pkt_count  = '0;
  assign gap_count  = '0;
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_la_rle_decoder.sv
// Directed bench for la_rle_decoder: latency, gaps, throughput, backpressure, fill and flush.
module tb_la_rle_decoder;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n;
  logic        dec_enable;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [1:0]  s_tuser;
  logic [23:0] wave_data;
  logic        wave_valid;
  logic        wave_gap;
  logic        wave_last;
  logic        wave_ready;
  logic [15:0] pkt_count;
  logic [15:0] gap_count;
  logic [31:0] beat_count;

  always #5 axi_clk = ~axi_clk;

  la_rle_decoder dut (
    .axi_clk    (axi_clk),
    .axi_reset_n(axi_reset_n),
    .dec_enable (dec_enable),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .s_tuser    (s_tuser),
    .wave_data  (wave_data),
    .wave_valid (wave_valid),
    .wave_gap   (wave_gap),
    .wave_last  (wave_last),
    .wave_ready (wave_ready),
    .pkt_count  (pkt_count),
    .gap_count  (gap_count),
    .beat_count (beat_count)
  );

  typedef struct packed {
    logic        gap;
    logic        last;
    logic [23:0] data;
    logic [31:0] cyc;
  } beat_t;

  beat_t       beats[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] cyc = 0;
  logic        stall_prev = 1'b0;
  logic [23:0] stall_data = '0;
  logic [23:0] exp_d3 [4] = '{24'h1, 24'h1, 24'h1, 24'h2};
  logic        exp_g3 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    int t = 0;
    s_tdata  = w;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready && t < 50) begin
      step();
      t++;
    end
    if (!s_tready) chk("send_timeout", {31'b0, s_tready}, 32'd1);
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t = 0;
    while (beats.size() < n && t < budget) begin
      step();
      t++;
    end
  endtask

  always @(posedge axi_clk) cyc <= cyc + 1;

  // Beat monitor plus hold check while stalled
  always @(negedge axi_clk) begin
    if (stall_prev)
      chk("stall_hold", {7'b0, wave_valid, wave_data}, {8'h01, stall_data});
    if (wave_valid && wave_ready)
      beats.push_back('{gap: wave_gap, last: wave_last, data: wave_data, cyc: cyc});
    stall_prev = axi_reset_n && dec_enable && wave_valid && !wave_ready;
    stall_data = wave_data;
  end

  initial begin
    int k;
    logic will;
    logic [31:0] b0, p0;
    axi_reset_n = 1'b0;
    dec_enable  = 1'b1;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    s_tuser     = 2'b11;
    wave_ready  = 1'b1;
    step(); step(); step();

    // Reset state
    chk("rst_tready", {31'b0, s_tready}, 32'd0);
    chk("rst_valid",  {31'b0, wave_valid}, 32'd0);
    chk("rst_gap",    {31'b0, wave_gap}, 32'd0);
    chk("rst_last",   {31'b0, wave_last}, 32'd0);
    chk("rst_data",   {8'b0, wave_data}, 32'd0);
    chk("rst_pkt",    {16'b0, pkt_count}, 32'd0);
    chk("rst_gapcnt", {16'b0, gap_count}, 32'd0);
    chk("rst_beat",   beat_count, 32'd0);
    axi_reset_n = 1'b1;
    chk("tready_before_edge", {31'b0, s_tready}, 32'd0);
    step();
    chk("tready_after_release", {31'b0, s_tready}, 32'd1);

    // Single rc=3 word with latency check
    beats.delete();
    send(32'h0300_ABCD, 1'b0);
    chk("lat_n1_valid", {31'b0, wave_valid}, 32'd0);
    step();
    chk("lat_n2_valid", {31'b0, wave_valid}, 32'd1);
    chk("lat_n2_data",  {8'b0, wave_data}, 32'h00ABCD);
    wait_beats(3, 20);
    step(); step();
    chk("t1_count", beats.size(), 32'd3);
    chk("t1_idle",  {31'b0, wave_valid}, 32'd0);
    foreach (beats[i]) begin
      chk("t1_data", {8'b0, beats[i].data}, 32'h00ABCD);
      chk("t1_gap",  {31'b0, beats[i].gap}, 32'd0);
      chk("t1_last", {31'b0, beats[i].last}, 32'd0);
    end

    // Data, null gap, data
    beats.delete();
    send(32'h0200_0001, 1'b0);
    send(32'h0000_0000, 1'b0);
    send(32'h0100_0002, 1'b0);
    wait_beats(4, 30);
    step(); step();
    chk("t2_count", beats.size(), 32'd4);
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      chk("t2_data", {8'b0, beats[i].data}, {8'b0, exp_d3[i]});
      chk("t2_gap",  {31'b0, beats[i].gap}, {31'b0, exp_g3[i]});
    end

    // Eight back-to-back rc=1 words, last flagged
    beats.delete();
    for (int i = 1; i <= 8; i++) send(32'h0100_0000 + i, (i == 8));
    wait_beats(8, 30);
    step(); step();
    chk("t3_count", beats.size(), 32'd8);
    for (int i = 0; i < 8 && i < beats.size(); i++) begin
      chk("t3_data", {8'b0, beats[i].data}, i + 1);
      chk("t3_last", {31'b0, beats[i].last}, (i == 7) ? 32'd1 : 32'd0);
      if (i > 0) chk("t3_nobubble", beats[i].cyc - beats[i-1].cyc, 32'd1);
    end

    // rc=255 with wave_ready toggling every cycle
    beats.delete();
    b0 = beat_count;
    p0 = {16'b0, pkt_count};
    send(32'hFF00_0077, 1'b0);
    for (int t = 0; t < 560; t++) begin
      wave_ready = (t % 2 == 1);
      step();
    end
    wave_ready = 1'b1;
    step();
    chk("t4_count", beats.size(), 32'd255);
    chk("t4_idle",  {31'b0, wave_valid}, 32'd0);
    chk("t4_data0", {8'b0, beats[0].data}, 32'h77);
    chk("t4_dataN", {8'b0, beats[beats.size()-1].data}, 32'h77);
`ifdef LA_RLE_DEC_STATS_EN
    chk("t4_beat_count", beat_count - b0, 32'd255);
    chk("t4_pkt_count",  {16'b0, pkt_count} - p0, 32'd1);
`else
    chk("t4_beat_count_off", beat_count, 32'd0);
    chk("t4_pkt_count_off",  p0, 32'd0);
`endif

    // Fill with downstream stalled
    beats.delete();
    wave_ready = 1'b0;
    k = 0;
    for (int t = 0; t < 12 && k < 6; t++) begin
      s_tdata  = 32'h0100_0011 + k;
      s_tvalid = 1'b1;
      will     = s_tready;
      step();
      if (will) k++;
    end
    s_tvalid = 1'b0;
    chk("t5_accepted", k, 32'd5);
    chk("t5_tready_full", {31'b0, s_tready}, 32'd0);
    wave_ready = 1'b1;
    wait_beats(5, 40);
    step(); step();
    chk("t5_count", beats.size(), 32'd5);
    for (int i = 0; i < 5 && i < beats.size(); i++)
      chk("t5_order", {8'b0, beats[i].data}, 32'h11 + i);

    // Flush mid-word, then recover
    beats.delete();
    send(32'h6400_0099, 1'b0);
    wait_beats(10, 30);
    dec_enable = 1'b0;
    step();
    chk("t6_valid_off",  {31'b0, wave_valid}, 32'd0);
    chk("t6_tready_off", {31'b0, s_tready}, 32'd0);
    beats.delete();
    step(); step();
    chk("t6_no_beats", beats.size(), 32'd0);
    dec_enable = 1'b1;
    step();
    send(32'h0100_0055, 1'b0);
    wait_beats(1, 20);
    step(); step();
    chk("t6_count", beats.size(), 32'd1);
    chk("t6_data",  {8'b0, beats[0].data}, 32'h55);
    chk("t6_idle",  {31'b0, wave_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
